// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between the bus sources and the bus_grant_arbiter.
// The master side drives requests; the slave side (the arbiter) drives the grant.
interface bus_grant_arbiter_if #(
    parameter int N_SRC = 32,
    parameter int IDX_W = 5
);
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;

    modport master (output req, input grant, grant_valid, grant_idx, busy);
    modport slave  (input req, output grant, grant_valid, grant_idx, busy);
endinterface

// File: rtl/bus_grant_arbiter.sv
// One-hot bus grant arbiter feeding the 32-to-5 bus-source encoder.
// Round-robin by default; define BUS_ARB_FIXED_PRIO_EN for highest-index-wins.
//
// state | meaning
// IDLE  | no grant driven; a set request is granted at the next edge
// GRANT | one source owns the bus until it releases or is preempted
module bus_grant_arbiter #(
    parameter int N_SRC    = 32,
    parameter int IDX_W    = 5,
    parameter int HOLD_MAX = 0
) (
    input  logic              clk,
    input  logic              clr,
    bus_grant_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_TOP = (HOLD_MAX > 0) ? HC_W'(HOLD_MAX - 1) : '0;
    localparam logic [N_SRC-1:0] ONE_SRC = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [N_SRC-1:0] grant_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [HC_W-1:0]  hold_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             holder_req;
    logic             others_pend;
    logic             preempt;

`ifdef BUS_ARB_FIXED_PRIO_EN
    // Ascending scan: the last hit is the highest set index.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.req[i]) begin
                win_idx   = IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Index arithmetic wraps naturally in IDX_W bits since N_SRC = 2**IDX_W.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!win_found && bus.req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end
`endif

    assign holder_req  = |(bus.req & grant_q);
    assign others_pend = |(bus.req & ~grant_q);
    assign preempt     = (HOLD_MAX > 0) && (hold_cnt == HOLD_TOP) && others_pend;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            hold_cnt <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        grant_q  <= ONE_SRC << win_idx;
                        idx_q    <= win_idx;
                        valid_q  <= 1'b1;
                        hold_cnt <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
                        rr_ptr   <= win_idx + IDX_W'(1);
`endif
                    end
                end
                default: begin
                    // Release and preemption both force a zero-grant turnaround cycle.
                    if (!holder_req || preempt) begin
                        state    <= IDLE;
                        grant_q  <= '0;
                        idx_q    <= '0;
                        valid_q  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_TOP) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
    assign bus.busy        = state;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter: vector table plus reset/preemption sequences.
// Expectations switch with BUS_ARB_FIXED_PRIO_EN to match the selected arbitration.
module tb_bus_grant_arbiter;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    bus_grant_arbiter_if #(.N_SRC(32), .IDX_W(5)) bus0 ();
    bus_grant_arbiter_if #(.N_SRC(32), .IDX_W(5)) bus4 ();

    bus_grant_arbiter #(.N_SRC(32), .IDX_W(5), .HOLD_MAX(0)) dut0 (
        .clk(clk), .clr(clr), .bus(bus0)
    );
    bus_grant_arbiter #(.N_SRC(32), .IDX_W(5), .HOLD_MAX(4)) dut4 (
        .clk(clk), .clr(clr), .bus(bus4)
    );

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic [31:0] eg;
        logic [4:0]  ei;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic [31:0] req, input int idx);
        vec_t v;
        v.rst = rst;
        v.req = req;
        v.eg  = (idx < 0) ? 32'h0 : (32'h1 << idx);
        v.ei  = (idx < 0) ? 5'd0 : 5'(idx);
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] g, input logic v,
                         input logic [4:0] i, input logic b, input int exp_idx);
        logic [31:0] eg;
        logic        ev;
        logic [4:0]  ei;
        eg = (exp_idx < 0) ? 32'h0 : (32'h1 << exp_idx);
        ev = (exp_idx >= 0);
        ei = (exp_idx < 0) ? 5'd0 : 5'(exp_idx);
        n_vec++;
        if (g !== eg || v !== ev || i !== ei || b !== ev) begin
            n_bad++;
            $display("FAIL %s: got grant=%h valid=%b idx=%0d busy=%b, want grant=%h valid=%b idx=%0d busy=%b",
                     name, g, v, i, b, eg, ev, ei, ev);
        end
    endtask

    int exp4[11];
    int exp0_hold;
    bit seen;

    initial begin
        bus0.req = '0;
        bus4.req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut0", bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy, -1);
        check("reset_dut4", bus4.grant, bus4.grant_valid, bus4.grant_idx, bus4.busy, -1);
        clr = 1'b0;

        // Async clear mid-grant, then regrant one edge after release of clr.
        bus0.req = 32'h0000_0020;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            step();
            seen = bus0.grant_valid;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL reset_wait_grant: got no grant_valid within 5 cycles, want grant_valid=1");
        end
        check("pre_clr_grant", bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy, 5);
        #2;
        clr = 1'b1;
        #1;
        check("async_clr", bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy, -1);
        clr = 1'b0;
        step();
        check("post_clr_regrant", bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy, 5);
        bus0.req = '0;
        step();
        check("post_clr_release", bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy, -1);

        // Single source held four cycles then released.
        add(1, 32'h0000_0020, 5);
        add(0, 32'h0000_0020, 5);
        add(0, 32'h0000_0020, 5);
        add(0, 32'h0000_0020, 5);
        add(0, 32'h0000_0000, -1);
        add(0, 32'h0000_0000, -1);
`ifdef BUS_ARB_FIXED_PRIO_EN
        add(1, 32'h0000_0081, 7);
        add(0, 32'h0000_0001, -1);
        add(0, 32'h0000_0081, 7);
        add(0, 32'h0000_0080, 7);
        add(0, 32'h0000_0001, -1);
        add(0, 32'h0000_0001, 0);
        add(0, 32'h0000_0081, 0);
        add(0, 32'h0000_0080, -1);
        add(0, 32'h0000_0081, 7);
        add(0, 32'h0000_0000, -1);
`else
        // Round-robin order 0, 1, 31, 0 with bubbles.
        add(1, 32'h8000_0003, 0);
        add(0, 32'h8000_0002, -1);
        add(0, 32'h8000_0003, 1);
        add(0, 32'h8000_0001, -1);
        add(0, 32'h8000_0003, 31);
        add(0, 32'h0000_0003, -1);
        add(0, 32'h8000_0003, 0);
        add(0, 32'h8000_0002, -1);
        // Wrap: grant 31 leaves rr_ptr at 0, so 0 beats 30.
        add(0, 32'h8000_0000, 31);
        add(0, 32'h0000_0000, -1);
        add(0, 32'h4000_0001, 0);
        add(0, 32'h4000_0000, -1);
        add(0, 32'h4000_0000, 30);
        add(0, 32'h0000_0000, -1);
        // Arrivals during a grant do not disturb it.
        add(0, 32'h0000_0100, 8);
        add(0, 32'h0000_0301, 8);
        add(0, 32'h0000_0300, 8);
        add(0, 32'h0000_0201, -1);
        add(0, 32'h0000_0201, 9);
        add(0, 32'h0000_0000, -1);
`endif

        foreach (tbl[k]) begin
            if (tbl[k].rst) pulse_clr();
            bus0.req = tbl[k].req;
            step();
            check($sformatf("vec%0d", k), bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.busy,
                  tbl[k].eg == 0 ? -1 : int'(tbl[k].ei));
            if (tbl[k].eg != 0 && tbl[k].eg != (32'h1 << tbl[k].ei)) begin
                n_vec++;
                n_bad++;
                $display("FAIL vec%0d_table: got inconsistent entry, want one-hot matching idx", k);
            end
        end

        // Preemption with HOLD_MAX=4 against indefinite hold with HOLD_MAX=0.
`ifdef BUS_ARB_FIXED_PRIO_EN
        exp4 = '{7, 7, 7, 7, -1, 7, 7, 7, 7, -1, 7};
        exp0_hold = 7;
`else
        exp4 = '{3, 3, 3, 3, -1, 7, 7, 7, 7, -1, 3};
        exp0_hold = 3;
`endif
        pulse_clr();
        bus0.req = 32'h0000_0088;
        bus4.req = 32'h0000_0088;
        for (int c = 0; c < 11; c++) begin
            step();
            check($sformatf("preempt_h4_c%0d", c), bus4.grant, bus4.grant_valid, bus4.grant_idx,
                  bus4.busy, exp4[c]);
            check($sformatf("hold_h0_c%0d", c), bus0.grant, bus0.grant_valid, bus0.grant_idx,
                  bus0.busy, exp0_hold);
        end

        // Lone holder is never preempted.
        pulse_clr();
        bus0.req = '0;
        bus4.req = 32'h0000_0008;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("lone_h4_c%0d", c), bus4.grant, bus4.grant_valid, bus4.grant_idx,
                  bus4.busy, 3);
        end
        bus4.req = '0;
        step();
        check("lone_h4_release", bus4.grant, bus4.grant_valid, bus4.grant_idx, bus4.busy, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
